// File: rtl/signed_sum_accumulator_if.sv
// Stream bundle for the signed sum accumulator: sample input channel and
// block-total output channel, each with a valid/ready handshake.
interface signed_sum_accumulator_if #(
  parameter int WLin  = 3,
  parameter int WLout = 5
);
  logic signed [WLin-1:0]  in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WLout-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sat;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sat
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sat
  );
endinterface

// File: rtl/signed_sum_accumulator.sv
// Accumulates NSAMP signed samples per block and presents the saturated block
// total on a registered valid/ready output; one block in flight at a time.
module signed_sum_accumulator #(
  parameter int WLin  = 3,
  parameter int NSAMP = 4,
  parameter int WLout = 5,
  parameter int WLacc = WLin + $clog2(NSAMP)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  signed_sum_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(NSAMP);
  // One guard bit above the wider of the two widths keeps the limit compare exact.
  localparam int WX = ((WLacc > WLout) ? WLacc : WLout) + 1;
  localparam logic signed [WX-1:0] ONE    = {{(WX-1){1'b0}}, 1'b1};
  localparam logic signed [WX-1:0] SAT_HI = (ONE <<< (WLout-1)) - ONE;
  localparam logic signed [WX-1:0] SAT_LO = ~SAT_HI;
  localparam logic [CNT_W-1:0]     LAST   = CNT_W'(NSAMP-1);

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  function automatic logic signed [WLout-1:0] sat_val(input logic signed [WLacc-1:0] s);
    logic signed [WX-1:0] sx;
    sx = WX'(s);
    if (sx > SAT_HI)      return SAT_HI[WLout-1:0];
    else if (sx < SAT_LO) return SAT_LO[WLout-1:0];
    else                  return sx[WLout-1:0];
  endfunction

  function automatic logic sat_flag(input logic signed [WLacc-1:0] s);
    logic signed [WX-1:0] sx;
    sx = WX'(s);
    return (sx > SAT_HI) || (sx < SAT_LO);
  endfunction

  state_t                  state_q, state_d;
  logic signed [WLacc-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic signed [WLout-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_sat_q, out_sat_d;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    sum         = acc_q + WLacc'(bus.in_data);

    if (clr) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      out_sat_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          // in_ready_q is low only for the first cycle after reset release.
          in_ready_d = 1'b1;
          if (bus.in_valid && in_ready_q) begin
            if (cnt_q == LAST) begin
              out_data_d  = sat_val(sum);
              out_sat_d   = sat_flag(sum);
              out_valid_d = 1'b1;
              in_ready_d  = 1'b0;
              state_d     = ST_HOLD;
              acc_d       = '0;
              cnt_d       = '0;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          in_ready_d = 1'b0;
          if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sat   = out_sat_q;

endmodule
